// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package imem_pkg;

   typedef enum logic [1:0] {
      RUN,
      LOAD,
      HALT
   } state_e;

   localparam int unsigned INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} pairs; clear wins over push.
module fetch_fifo
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  fetch_entry_t               din,
   output fetch_entry_t               dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     entries_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign dout    = entries_q[rd_ptr_q];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries_q[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            entries_q[wr_ptr_q] <= din;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the instruction memory port, shared with a program loader.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DEPTH    = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_mode,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [31:0]        ld_data,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [31:0]        instr_pc,
   output logic [31:0]        instr_data,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata,
   output logic               misalign_err
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   state_e       state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  tag_q, tag_d;
   logic         inflight_q, inflight_d;
   logic         misalign_q, misalign_d;

   logic         fifo_clear;
   logic         fifo_push;
   logic         fifo_pop;
   logic         fifo_empty;
   logic         fifo_full;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t push_entry;
   fetch_entry_t head;

   assign instr_valid  = !fifo_empty;
   assign instr_pc     = head.pc;
   assign instr_data   = head.instr;
   assign misalign_err = misalign_q;
   assign fifo_pop     = instr_valid && instr_ready;
   // A flush in the same cycle outranks this push inside the FIFO, which drops the response.
   assign fifo_push    = inflight_q;
   assign push_entry   = '{pc: tag_q, instr: mem_rdata};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      tag_d      = tag_q;
      inflight_d = 1'b0;
      misalign_d = misalign_q;
      fifo_clear = 1'b0;
      ld_ready   = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (!reset) begin
         unique case (state_q)
            RUN: begin
               if (load_mode) begin
                  state_d    = LOAD;
                  fifo_clear = 1'b1;
               end else if (redirect_valid) begin
                  fifo_clear = 1'b1;
                  if (redirect_pc[1:0] != 2'b00) begin
                     state_d    = HALT;
                     misalign_d = 1'b1;
                  end else begin
                     fetch_pc_d = redirect_pc;
                  end
               end else if ((!fifo_full && (32'(fifo_count) + 32'(inflight_q) < DEPTH))
                            || fifo_pop) begin
                  mem_en     = 1'b1;
                  mem_addr   = fetch_pc_q[ADDR_W+1:2];
                  tag_d      = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + PC_STEP;
                  inflight_d = 1'b1;
               end
            end
            LOAD: begin
               ld_ready = 1'b1;
               if (ld_valid) begin
                  mem_en    = 1'b1;
                  mem_we    = 1'b1;
                  mem_addr  = ld_addr;
                  mem_wdata = ld_data;
               end
               if (!load_mode) begin
                  state_d    = RUN;
                  fetch_pc_d = RESET_PC;
               end
            end
            HALT: begin
               fifo_clear = 1'b1;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (fifo_clear),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (push_entry),
      .dout  (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a synchronous-read IMEM model.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_mode;
   logic        ld_valid;
   logic        ld_ready;
   logic [3:0]  ld_addr;
   logic [31:0] ld_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_pc;
   logic [31:0] instr_data;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        misalign_err;

   logic [31:0] tb_mem [16];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .ADDR_W   (4),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .load_mode      (load_mode),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_pc       (instr_pc),
      .instr_data     (instr_data),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .misalign_err   (misalign_err)
   );

   initial begin
      for (int k = 0; k < 16; k++) tb_mem[k] = 32'h1000_0000 + k;
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; load_mode = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

      tick(); #1;
      chk("rst_en", 32'(mem_en), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_ldrdy", 32'(ld_ready), 32'd0);
      chk("rst_mis", 32'(misalign_err), 32'd0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_data", instr_data, 32'h0);

      // Streaming fetch after release
      tick(); reset = 1'b0; instr_ready = 1'b1; #1;
      chk("s0_en", 32'(mem_en), 32'd1);
      chk("s0_addr", 32'(mem_addr), 32'd0);
      chk("s0_valid", 32'(instr_valid), 32'd0);
      tick(); #1;
      chk("s1_addr", 32'(mem_addr), 32'd1);
      chk("s1_valid", 32'(instr_valid), 32'd0);
      tick(); #1;
      chk("s2_valid", 32'(instr_valid), 32'd1);
      chk("s2_pc", instr_pc, 32'h0);
      chk("s2_data", instr_data, 32'h1000_0000);
      chk("s2_addr", 32'(mem_addr), 32'd2);
      tick(); #1;
      chk("s3_pc", instr_pc, 32'h4);
      chk("s3_data", instr_data, 32'h1000_0001);
      chk("s3_addr", 32'(mem_addr), 32'd3);
      tick(); #1;
      chk("s4_pc", instr_pc, 32'h8);
      chk("s4_addr", 32'(mem_addr), 32'd4);
      tick(); #1;
      chk("s5_pc", instr_pc, 32'hC);
      chk("s5_data", instr_data, 32'h1000_0003);
      chk("s5_addr", 32'(mem_addr), 32'd5);

      // Asynchronous reset mid-stream, then backpressure
      tick(); reset = 1'b1; #1;
      chk("mrst_valid", 32'(instr_valid), 32'd0);
      chk("mrst_en", 32'(mem_en), 32'd0);
      tick(); reset = 1'b0; #1;
      chk("b0_addr", 32'(mem_addr), 32'd0);
      tick(); #1;
      chk("b1_addr", 32'(mem_addr), 32'd1);
      tick(); instr_ready = 1'b0; #1;
      chk("b2_valid", 32'(instr_valid), 32'd1);
      chk("b2_pc", instr_pc, 32'h0);
      chk("b2_en", 32'(mem_en), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         chk("bhold_en", 32'(mem_en), 32'd0);
         chk("bhold_pc", instr_pc, 32'h0);
         chk("bhold_data", instr_data, 32'h1000_0000);
      end
      tick(); instr_ready = 1'b1; #1;
      chk("b7_pc", instr_pc, 32'h0);
      chk("b7_en", 32'(mem_en), 32'd1);
      chk("b7_addr", 32'(mem_addr), 32'd2);

      // Redirect while the pc 8 read is in flight
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0020; #1;
      chk("r0_pc", instr_pc, 32'h4);
      chk("r0_data", instr_data, 32'h1000_0001);
      chk("r0_en", 32'(mem_en), 32'd0);
      tick(); redirect_valid = 1'b0; #1;
      chk("r1_valid", 32'(instr_valid), 32'd0);
      chk("r1_addr", 32'(mem_addr), 32'd8);
      tick(); #1;
      chk("r2_valid", 32'(instr_valid), 32'd0);
      chk("r2_addr", 32'(mem_addr), 32'd9);
      tick(); #1;
      chk("r3_pc", instr_pc, 32'h20);
      chk("r3_data", instr_data, 32'h1000_0008);

      // PC wrap
      tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
      chk("w0_en", 32'(mem_en), 32'd0);
      tick(); redirect_valid = 1'b0; #1;
      chk("w1_addr", 32'(mem_addr), 32'd14);
      tick(); #1;
      chk("w2_addr", 32'(mem_addr), 32'd15);
      chk("w2_valid", 32'(instr_valid), 32'd0);
      tick(); #1;
      chk("w3_addr", 32'(mem_addr), 32'd0);
      chk("w3_pc", instr_pc, 32'hFFFF_FFF8);
      chk("w3_data", instr_data, 32'h1000_000E);
      tick(); #1;
      chk("w4_pc", instr_pc, 32'hFFFF_FFFC);
      chk("w4_data", instr_data, 32'h1000_000F);
      tick(); #1;
      chk("w5_pc", instr_pc, 32'h0);
      chk("w5_data", instr_data, 32'h1000_0000);

      // Load mode beats a simultaneous redirect; redirects ignored while loading
      tick(); load_mode = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      chk("l0_ldrdy", 32'(ld_ready), 32'd0);
      chk("l0_en", 32'(mem_en), 32'd0);
      tick(); redirect_pc = 32'h22; ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 32'hDEAD_BEEF;
      #1;
      chk("l1_ldrdy", 32'(ld_ready), 32'd1);
      chk("l1_en", 32'(mem_en), 32'd1);
      chk("l1_we", 32'(mem_we), 32'd1);
      chk("l1_addr", 32'(mem_addr), 32'd3);
      chk("l1_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("l1_valid", 32'(instr_valid), 32'd0);
      tick(); ld_valid = 1'b0; redirect_valid = 1'b0; load_mode = 1'b0; #1;
      chk("l2_ldrdy", 32'(ld_ready), 32'd1);
      chk("l2_en", 32'(mem_en), 32'd0);
      chk("l2_mis", 32'(misalign_err), 32'd0);
      tick(); #1;
      chk("l3_ldrdy", 32'(ld_ready), 32'd0);
      chk("l3_en", 32'(mem_en), 32'd1);
      chk("l3_we", 32'(mem_we), 32'd0);
      chk("l3_addr", 32'(mem_addr), 32'd0);
      tick(); tick(); #1;
      chk("l5_pc", instr_pc, 32'h0);
      tick(); tick(); tick(); #1;
      chk("l8_pc", instr_pc, 32'hC);
      chk("l8_data", instr_data, 32'hDEAD_BEEF);

      // Misaligned redirect halts until reset
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h22; #1;
      chk("m0_en", 32'(mem_en), 32'd0);
      chk("m0_mis", 32'(misalign_err), 32'd0);
      tick(); redirect_valid = 1'b0; load_mode = 1'b1; #1;
      chk("m1_mis", 32'(misalign_err), 32'd1);
      chk("m1_valid", 32'(instr_valid), 32'd0);
      chk("m1_en", 32'(mem_en), 32'd0);
      tick(); #1;
      chk("m2_ldrdy", 32'(ld_ready), 32'd0);
      chk("m2_en", 32'(mem_en), 32'd0);
      chk("m2_mis", 32'(misalign_err), 32'd1);
      #3; reset = 1'b1; #1;
      chk("m3_mis", 32'(misalign_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
